// File: rtl/gfx_rom_sched.sv
// Graphics ROM bus time-slot scheduler: fixed per-group fetch slots and latch strobes.
// Optional CPU readback slots are enabled by defining GFXSCHED_CPU_SLOT_EN.
module gfx_rom_sched (
  input  logic        clk_24M,
  input  logic        RES,
  input  logic        ce_6M,
  input  logic        line_start,
  input  logic        fetch_en,
  input  logic [17:0] fix_addr,
  input  logic [17:0] a_addr,
  input  logic [17:0] b_addr,
  input  logic        cpu_req,
  input  logic [17:0] cpu_addr,
  output logic        cpu_ack,
  output logic        rom_req,
  output logic [17:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic [31:0] VC,
  output logic        lat_fix,
  output logic        lat_a,
  output logic        lat_b,
  output logic [2:0]  px,
  output logic [7:0]  ovr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [1:0] ID_CPU = 2'd0;
  localparam logic [1:0] ID_A   = 2'd1;
  localparam logic [1:0] ID_B   = 2'd2;
  localparam logic [1:0] ID_FIX = 2'd3;

  state_t      state;
  state_t      state_n;
  logic [1:0]  cur_id;
  logic [2:0]  cur_dl;
  logic        late;
  logic [3:0]  pend;
  logic [3:0]  pend_n;
  logic [2:0]  cpu_dl;
  logic        cpu_ok;
  logic        want;
  logic        layer;
  logic [1:0]  sel_id;
  logic [17:0] sel_addr;
  logic [2:0]  sel_dl;
  logic        issue;
  logic        skip;
  logic        ack_now;
  logic        late_now;
  logic [3:0]  dl_hit;
  logic [3:0]  stb;

`ifdef GFXSCHED_CPU_SLOT_EN
  assign cpu_ok  = cpu_req;
  assign cpu_ack = stb[ID_CPU];
`else
  logic unused_cpu;
  assign unused_cpu = cpu_req;
  assign cpu_ok     = 1'b0;
  assign cpu_ack    = 1'b0;
`endif

  // Pick the requester owning the current even pixel slot.
  always_comb begin
    want     = 1'b0;
    layer    = 1'b0;
    sel_id   = ID_CPU;
    sel_addr = cpu_addr;
    sel_dl   = 3'(px + 3'd1);
    if (ce_6M && !px[0]) begin
      if (px == 3'd0) begin
        want = cpu_ok;
      end else if (fetch_en) begin
        want  = 1'b1;
        layer = 1'b1;
        unique case (1'b1)
          (px == 3'd2): begin
            sel_id   = ID_A;
            sel_addr = a_addr;
            sel_dl   = 3'd5;
          end
          (px == 3'd4): begin
            sel_id   = ID_B;
            sel_addr = b_addr;
            sel_dl   = 3'd7;
          end
          default: begin
            sel_id   = ID_FIX;
            sel_addr = fix_addr;
            sel_dl   = 3'd1;
          end
        endcase
      end else begin
        want = cpu_ok;
      end
    end
  end

  assign issue    = want && (state != BUSY);
  assign skip     = want && layer && (state == BUSY);
  assign ack_now  = (state == BUSY) && rom_ack;
  assign late_now = (state == BUSY) && !late && ce_6M && (px == cur_dl);

  assign dl_hit[ID_CPU] = (px == cpu_dl);
  assign dl_hit[ID_A]   = (px == 3'd5);
  assign dl_hit[ID_B]   = (px == 3'd7);
  assign dl_hit[ID_FIX] = (px == 3'd1);
  assign stb            = {4{ce_6M}} & pend & dl_hit;

  assign lat_a   = stb[ID_A];
  assign lat_b   = stb[ID_B];
  assign lat_fix = stb[ID_FIX];

  // Next-state and pending-strobe bookkeeping.
  always_comb begin
    pend_n = pend & ~stb;
    if (ack_now && !late && !late_now) begin
      pend_n[cur_id] = 1'b1;
    end
    if (issue) begin
      state_n = BUSY;
    end else if ((state == BUSY) && !rom_ack) begin
      state_n = BUSY;
    end else if (pend_n != 4'd0) begin
      state_n = DONE;
    end else begin
      state_n = IDLE;
    end
  end

  // State register, pixel counter and pending strobes.
  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      state <= IDLE;
      pend  <= 4'd0;
      px    <= 3'd0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      if (ce_6M) begin
        px <= line_start ? 3'd0 : 3'(px + 3'd1);
      end
    end
  end

  // Outstanding request, ROM handshake and returned row.
  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      cur_id   <= ID_CPU;
      cur_dl   <= 3'd0;
      late     <= 1'b0;
      cpu_dl   <= 3'd0;
      rom_req  <= 1'b0;
      rom_addr <= 18'd0;
      VC       <= 32'd0;
    end else begin
      if (issue) begin
        cur_id   <= sel_id;
        cur_dl   <= sel_dl;
        rom_addr <= sel_addr;
        rom_req  <= 1'b1;
        late     <= 1'b0;
      end else begin
        if (late_now) begin
          late <= 1'b1;
        end
        if (ack_now) begin
          rom_req <= 1'b0;
        end
      end
      if (ack_now) begin
        VC <= rom_data;
        if (cur_id == ID_CPU) begin
          cpu_dl <= cur_dl;
        end
      end
    end
  end

  // Saturating count of late acks and skipped layer slots.
  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      ovr_cnt <= 8'd0;
    end else if ((late_now || skip) && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= 8'(ovr_cnt + 8'd1);
    end
  end

endmodule

// File: tb/tb_gfx_rom_sched.sv
// Scoreboard bench for gfx_rom_sched: randomized traffic against a slot-rule model.
// Follows GFXSCHED_CPU_SLOT_EN the same way as the design.
`timescale 1ns/1ps
module tb_gfx_rom_sched;

  logic        clk_24M = 1'b0;
  logic        RES = 1'b1;
  logic        ce_6M = 1'b0;
  logic        line_start = 1'b0;
  logic        fetch_en = 1'b0;
  logic [17:0] fix_addr = '0;
  logic [17:0] a_addr = '0;
  logic [17:0] b_addr = '0;
  logic        cpu_req = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic        cpu_ack;
  logic        rom_req;
  logic [17:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [31:0] rom_data = '0;
  logic [31:0] VC;
  logic        lat_fix;
  logic        lat_a;
  logic        lat_b;
  logic [2:0]  px;
  logic [7:0]  ovr_cnt;

  gfx_rom_sched dut (
    .clk_24M(clk_24M), .RES(RES), .ce_6M(ce_6M),
    .line_start(line_start), .fetch_en(fetch_en),
    .fix_addr(fix_addr), .a_addr(a_addr), .b_addr(b_addr),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .VC(VC), .lat_fix(lat_fix),
    .lat_a(lat_a), .lat_b(lat_b), .px(px), .ovr_cnt(ovr_cnt)
  );

  always #5 clk_24M = ~clk_24M;

  localparam int ID_CPU = 0;
  localparam int ID_A   = 1;
  localparam int ID_B   = 2;
  localparam int ID_FIX = 3;
`ifdef GFXSCHED_CPU_SLOT_EN
  localparam bit CPU_EN = 1'b1;
`else
  localparam bit CPU_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [17:0] addr;
  } iss_t;
  typedef struct {
    int          cyc;
    int          id;
    int          px;
    logic [31:0] vc;
  } stb_t;

  iss_t iss_q[$];
  stb_t stb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // reference model state
  int          m_px;
  bit          m_busy;
  int          m_cur;
  int          m_dl;
  int          m_ack_at;
  logic [17:0] m_addr;
  bit          m_late;
  bit          m_pend[4];
  int          m_cpu_dl;
  logic [31:0] m_vc;
  int          m_ovr;

  // stimulus controls
  bit g_fetch;
  int g_cpu_mode;
  int g_lat_a;
  int g_lat_lo;
  int g_lat_hi;
  bit g_ls;
  bit g_rand_fetch;
  int cpu_gap;
  bit cpu_drop;
  bit cpu_first;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [31:0] row(logic [17:0] a);
    return {a, 14'(~a[13:0] ^ 14'h1A5)};
  endfunction

  function automatic int dl_of(int id);
    case (id)
      ID_A:    return 5;
      ID_B:    return 7;
      ID_FIX:  return 1;
      default: return m_cpu_dl;
    endcase
  endfunction

  function automatic void bump();
    if (m_ovr < 255) m_ovr++;
  endfunction

  function automatic void model_reset();
    m_px = 0;
    m_busy = 0;
    m_cur = 0;
    m_dl = 0;
    m_ack_at = -1;
    m_addr = '0;
    m_late = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_cpu_dl = 0;
    m_vc = '0;
    m_ovr = 0;
  endfunction

  // one clk_24M cycle: drive inputs, then advance the model
  task automatic step();
    int          id;
    bit          busy_pre;
    logic [17:0] ad;
    int          lat;
    @(posedge clk_24M);
    #1;
    cyc++;
    ce_6M = (cyc % 4 == 0);
    line_start = 1'b0;
    if (g_ls && ce_6M && m_px == 3 && m_busy && m_cur == ID_A) begin
      line_start = 1'b1;
      g_ls = 0;
    end
    if (g_rand_fetch && ce_6M && m_px == 0) g_fetch = ($urandom_range(3, 0) != 0);
    fetch_en = g_fetch;
    a_addr = 18'($urandom);
    b_addr = 18'($urandom);
    fix_addr = 18'($urandom);
    if (cpu_drop) begin
      cpu_req = 1'b0;
      cpu_drop = 0;
      cpu_gap = (g_cpu_mode == 2) ? 0 : int'($urandom_range(20, 0));
    end else if (!cpu_req && g_cpu_mode != 0) begin
      if (cpu_gap > 0) cpu_gap--;
      else begin
        cpu_req = 1'b1;
        cpu_addr = cpu_first ? 18'h00123 : 18'($urandom);
        cpu_first = 0;
      end
    end
    rom_ack = m_busy && (cyc == m_ack_at);
    rom_data = rom_ack ? row(m_addr) : $urandom;

    busy_pre = m_busy;
    if (ce_6M) begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i] && m_px == dl_of(i)) begin
          stb_q.push_back('{cyc: cyc, id: i, px: m_px, vc: m_vc});
          m_pend[i] = 0;
          if (i == ID_CPU) cpu_drop = 1;
        end
      end
      if (busy_pre && !m_late && m_px == m_dl) begin
        m_late = 1;
        bump();
      end
    end
    if (rom_ack) begin
      m_vc = row(m_addr);
      m_busy = 0;
      if (!m_late) begin
        m_pend[m_cur] = 1;
        if (m_cur == ID_CPU) m_cpu_dl = m_dl;
      end
    end
    if (ce_6M && (m_px % 2 == 0)) begin
      id = -1;
      ad = cpu_addr;
      if (m_px != 0 && fetch_en) begin
        id = (m_px == 2) ? ID_A : (m_px == 4) ? ID_B : ID_FIX;
        ad = (m_px == 2) ? a_addr : (m_px == 4) ? b_addr : fix_addr;
      end else if (CPU_EN && cpu_req) begin
        id = ID_CPU;
      end
      if (id >= 0) begin
        if (busy_pre) begin
          if (id != ID_CPU) bump();
        end else begin
          m_busy = 1;
          m_cur = id;
          m_addr = ad;
          m_late = 0;
          m_dl = (id == ID_CPU) ? (m_px + 1) % 8 : dl_of(id);
          lat = (id == ID_A && g_lat_a > 0) ? g_lat_a
              : int'($urandom_range(g_lat_hi, g_lat_lo));
          m_ack_at = cyc + 1 + lat;
          iss_q.push_back('{cyc: cyc + 1, addr: ad});
        end
      end
    end
    if (ce_6M) m_px = line_start ? 0 : (m_px + 1) % 8;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, " px"}, 32'(px), 32'd0);
    chk({tag, " rom_req"}, 32'(rom_req), 32'd0);
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, " VC"}, VC, 32'd0);
    chk({tag, " strobes"}, 32'({lat_fix, lat_a, lat_b, cpu_ack}), 32'd0);
    chk({tag, " ovr_cnt"}, 32'(ovr_cnt), 32'd0);
  endtask

  // monitor: compare every ROM request and strobe against the scoreboard
  initial begin
    logic       req_d;
    logic [3:0] s;
    iss_t       ei;
    stb_t       es;
    req_d = 1'b0;
    forever begin
      @(negedge clk_24M);
      if (!RES) begin
        if (rom_req && !req_d) begin
          if (iss_q.size() == 0) begin
            chk("unexpected rom_req addr", 32'(rom_addr), 32'hFFFFFFFF);
          end else begin
            ei = iss_q.pop_front();
            chk("rom_req cycle", 32'(cyc), 32'(ei.cyc));
            chk("rom_addr", 32'(rom_addr), 32'(ei.addr));
          end
        end
        s = {lat_fix, lat_b, lat_a, cpu_ack};
        for (int i = 0; i < 4; i++) begin
          if (s[i]) begin
            if (stb_q.size() == 0) begin
              chk("unexpected strobe id", 32'(i), 32'hFFFFFFFF);
            end else begin
              es = stb_q.pop_front();
              chk("strobe id", 32'(i), 32'(es.id));
              chk("strobe cycle", 32'(cyc), 32'(es.cyc));
              chk("strobe px", 32'(px), 32'(es.px));
              chk("VC at strobe", VC, es.vc);
            end
          end
        end
      end
      req_d = rom_req;
    end
  end

  initial begin
    model_reset();
    g_fetch = 0;
    g_cpu_mode = 0;
    g_lat_a = 0;
    g_lat_lo = 2;
    g_lat_hi = 2;
    g_ls = 0;
    g_rand_fetch = 0;
    cpu_gap = 0;
    cpu_drop = 0;
    cpu_first = 1;

    repeat (3) @(posedge clk_24M);
    #1;
    check_idle_outputs("reset");
    RES = 1'b0;

    // steady fetching, fixed 2-cycle ack latency
    g_fetch = 1;
    run(320);
    chk("ovr after free-run", 32'(ovr_cnt), 32'd0);

    // random latencies, CPU traffic, fetch_en toggling
    g_cpu_mode = 1;
    g_rand_fetch = 1;
    g_lat_lo = 1;
    g_lat_hi = 8;
    run(2000);
    chk("ovr after random", 32'(ovr_cnt), 32'(m_ovr));

    // layer A acked too late, B slot lands while busy
    g_rand_fetch = 0;
    g_fetch = 1;
    g_cpu_mode = 0;
    g_lat_lo = 2;
    g_lat_hi = 2;
    run(40);
    g_lat_a = 11;
    run(64);
    g_lat_a = 0;
    run(40);
    chk("ovr after late A", 32'(ovr_cnt), 32'(m_ovr));

    // blanking: CPU held, one fetch per even slot
    g_fetch = 0;
    g_cpu_mode = 2;
    run(200);
    chk("ovr after blanking", 32'(ovr_cnt), 32'(m_ovr));

    // line_start while A outstanding at px=3
    g_cpu_mode = 0;
    g_fetch = 1;
    run(40);
    g_lat_a = 6;
    g_ls = 1;
    run(96);
    g_lat_a = 0;
    chk("line_start applied", 32'(g_ls), 32'd0);

    // drive the overrun counter into saturation
    g_lat_a = 11;
    run(4600);
    g_lat_a = 0;
    chk("ovr saturated", 32'(ovr_cnt), 32'd255);
    chk("ovr model", 32'(ovr_cnt), 32'(m_ovr));

    // drain
    g_fetch = 0;
    g_cpu_mode = 0;
    run(80);
    chk("issues left", 32'(iss_q.size()), 32'd0);
    chk("strobes left", 32'(stb_q.size()), 32'd0);

    // reset in the middle of a request, then a stray ack
    g_fetch = 1;
    g_lat_lo = 9;
    g_lat_hi = 9;
    g_lat_a = 9;
    for (int i = 0; i < 40 && !m_busy; i++) step();
    step();
    chk("rom_req before reset", 32'(rom_req), 32'd1);
    #2;
    RES = 1'b1;
    #1;
    check_idle_outputs("mid reset");
    iss_q.delete();
    stb_q.delete();
    model_reset();
    g_fetch = 0;
    fetch_en = 1'b0;
    ce_6M = 1'b0;
    @(posedge clk_24M);
    #1;
    RES = 1'b0;
    rom_ack = 1'b1;
    rom_data = 32'hDEADBEEF;
    @(posedge clk_24M);
    #1;
    rom_ack = 1'b0;
    @(posedge clk_24M);
    #1;
    chk("VC after stray ack", VC, 32'd0);
    chk("rom_req after stray ack", 32'(rom_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
